// File: rtl/player_input_port_pkg.sv
// player_io_pkg: shared definitions for the player input port.
//   - Register word offsets relative to BASE_ADR.
//   - CONTROL write bit positions (ARM, DISARM).
//   - STATUS read bit positions.
//   - io_state_t: buzzer FSM states.
package player_io_pkg;

    localparam logic [1:0] REG_STATUS  = 2'd0;
    localparam logic [1:0] REG_CODE    = 2'd1;
    localparam logic [1:0] REG_CONTROL = 2'd2;
    localparam logic [1:0] REG_RAW     = 2'd3;

    localparam int CTRL_ARM    = 0;
    localparam int CTRL_DISARM = 1;

    localparam int ST_LOCKED = 0;
    localparam int ST_IDX_LO = 1;   // first_idx occupies bits 2:1
    localparam int ST_ARMED  = 3;
    localparam int ST_ACT_LO = 4;   // act[3:0] occupies bits 7:4

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        LOCKED = 2'd2
    } io_state_t;

endpackage

// File: rtl/player_input_port_if.sv
// player_input_port_if: processor word bus into the I/O space.
//   adr       : word address              (master -> slave)
//   memread   : read strobe               (master -> slave)
//   memwrite  : write strobe              (master -> slave)
//   writedata : write data                (master -> slave)
//   rdata     : combinational read data   (slave -> master)
//   hit       : address is in the window  (slave -> master)
interface player_input_port_if;
    logic [15:0] adr;
    logic        memread;
    logic        memwrite;
    logic [15:0] writedata;
    logic [15:0] rdata;
    logic        hit;

    modport master (
        output adr, memread, memwrite, writedata,
        input  rdata, hit
    );

    modport slave (
        input  adr, memread, memwrite, writedata,
        output rdata, hit
    );
endinterface

// File: rtl/player_input_port_debounce.sv
// debounce_bit: conditions one player button.
//   clk : system clock
//   rst : asynchronous active-high reset
//   raw : button pin straight from the GPIO header
//   deb : debounced level, 1 = pressed
// The pin is normalised to pressed-high, passed through a two-flop
// synchronizer, then accepted only after DEBOUNCE_CYCLES consecutive
// synchronized samples that disagree with the current debounced level.
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic deb
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sample;
    logic          sync_p0;
    logic          sync_p1;
    logic [CW-1:0] cnt;

    assign sample = ACTIVE_LOW ? ~raw : raw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            cnt     <= '0;
            deb     <= 1'b0;
        end else begin
            // synchronizer stages
            sync_p0 <= sample;
            sync_p1 <= sync_p0;
            // debounce stage: the edge that would bring cnt to
            // DEBOUNCE_CYCLES accepts the new level instead
            if (sync_p1 == deb) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                deb <= sync_p1;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/player_input_port.sv
// player_input_port: memory-mapped buzzer port for four player controllers.
//   clk             : system clock
//   rst             : asynchronous active-high reset
//   gpins           : GPIO header, player n buttons on gpins[4n+3:4n]
//   bus             : processor word bus (slave side), registers at
//                     BASE_ADR+0 STATUS, +1 CODE, +2 CONTROL, +3 RAW
//   playerInputFlag : high while a player has buzzed in (LOCKED)
module player_input_port
    import player_io_pkg::*;
#(
    parameter logic [15:0] BASE_ADR        = 16'd43,
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [35:0]                gpins,
    player_input_port_if.slave         bus,
    output logic                       playerInputFlag
);

    logic [15:0] deb_bits;
    logic [3:0]  act;
    logic [3:0]  act_q;
    logic [3:0]  press;
    logic [1:0]  sel;
    logic [3:0]  sel_code;
    logic [15:0] offset;
    logic [1:0]  reg_sel;
    logic        in_window;
    logic        ctrl_wr;
    io_state_t   state;
    logic [1:0]  first_idx;
    logic [3:0]  first_code;
    logic [15:0] status;
    logic        unused_bits;

    // Lowest player index wins when several press in the same cycle.
    function automatic logic [1:0] first_player(input logic [3:0] ev);
        if (ev[0])      return 2'd0;
        else if (ev[1]) return 2'd1;
        else if (ev[2]) return 2'd2;
        else            return 2'd3;
    endfunction

    for (genvar i = 0; i < 16; i++) begin : g_btn
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_deb (
            .clk (clk),
            .rst (rst),
            .raw (gpins[i]),
            .deb (deb_bits[i])
        );
    end

    always_comb begin
        act = '0;
        for (int n = 0; n < 4; n++) begin
            act[n] = |deb_bits[4*n +: 4];
        end
    end

    assign press    = act & ~act_q;
    assign sel      = first_player(press);
    assign sel_code = deb_bits[{sel, 2'b00} +: 4];

    assign offset    = bus.adr - BASE_ADR;
    assign reg_sel   = offset[1:0];
    assign in_window = (bus.adr >= BASE_ADR) && (offset < 16'd4);
    assign bus.hit   = in_window;
    assign ctrl_wr   = bus.memwrite && in_window && (reg_sel == REG_CONTROL);

    assign unused_bits = ^{gpins[35:16], offset[15:2], bus.writedata[15:2]};

    // edge-detect / FSM stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_q           <= '0;
            state           <= IDLE;
            first_idx       <= '0;
            first_code      <= '0;
            playerInputFlag <= 1'b0;
        end else begin
            act_q <= act;
            // A CONTROL write discards a press landing on the same edge.
            if (ctrl_wr && bus.writedata[CTRL_DISARM]) begin
                state           <= IDLE;
                first_idx       <= '0;
                first_code      <= '0;
                playerInputFlag <= 1'b0;
            end else if (ctrl_wr && bus.writedata[CTRL_ARM]) begin
                state           <= ARMED;
                first_idx       <= '0;
                first_code      <= '0;
                playerInputFlag <= 1'b0;
            end else if (state == ARMED && (|press)) begin
                state           <= LOCKED;
                first_idx       <= sel;
                first_code      <= sel_code;
                playerInputFlag <= 1'b1;
            end
        end
    end

    always_comb begin
        status              = '0;
        status[ST_LOCKED]   = (state == LOCKED);
        status[ST_IDX_LO+:2] = first_idx;
        status[ST_ARMED]    = (state == ARMED);
        status[ST_ACT_LO+:4] = act;
    end

    // Simultaneous read and write strobes count as a write only.
    always_comb begin
        bus.rdata = '0;
        if (bus.memread && !bus.memwrite && in_window) begin
            case (reg_sel)
                REG_STATUS: bus.rdata = status;
                REG_CODE:   bus.rdata = {12'b0, first_code};
                REG_RAW:    bus.rdata = deb_bits;
                default:    bus.rdata = '0;
            endcase
        end
    end

endmodule

// File: doc/player_input_port.md
# player_input_port

Memory-mapped I/O responder for the four player controllers on the GPIO header. It synchronizes and debounces the sixteen player buttons, then runs an arm/lock buzzer FSM that records which player pressed first and that player's 4-bit button code. The processor reads the result, re-arms, or disarms through word registers in the I/O space next to `exmem`. `playerInputFlag` is driven to the memory block as the "a player has buzzed in" indication.

## Interface
- `BASE_ADR`, 16'd43: word address of register 0. The block decodes `BASE_ADR` .. `BASE_ADR+3`.
- `DEBOUNCE_CYCLES`, 500000: number of consecutive stable cycles needed to accept a button change. Minimum 1.
- `ACTIVE_LOW`, 1: 1 means a pressed button reads 0 on `gpins`.
- `clk`, in, 1: system clock. All state updates on the rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `gpins`, in, 36: GPIO header. Player n buttons are on `gpins[4n+3:4n]`, n = 0..3. Bits 35:16 are unused.
- `adr`, in, 16: processor word address.
- `memread`, in, 1: read strobe.
- `memwrite`, in, 1: write strobe.
- `writedata`, in, 16: write data.
- `rdata`, out, 16: read data, combinational.
- `hit`, out, 1: high when `adr` is in this block's 4-word window.
- `playerInputFlag`, out, 1: high while the FSM is in LOCKED.

## Operation
- Input conditioning, per button:
  - Invert if `ACTIVE_LOW`.
  - Two-flop synchronizer.
  - Debounce counter: it increments while the synchronized sample differs from the debounced state, and clears whenever they match. When it reaches `DEBOUNCE_CYCLES`, the debounced state takes the new value and the counter clears.
  - Counter width is $clog2(`DEBOUNCE_CYCLES`+1).
- Per-player activity: `act[n]` = OR of player n's four debounced bits. A press event is a 0->1 transition of `act[n]`, detected against a registered copy of `act`.
- FSM states: IDLE, ARMED, LOCKED. Reset state is IDLE.
  - IDLE -> ARMED on a CONTROL write with bit0 = 1.
  - ARMED -> LOCKED on any press event. On that edge, latch `first_idx` and `first_code` (that player's 4 debounced bits, as sampled on the same edge).
  - Simultaneous press events: the lowest player index wins.
  - LOCKED ignores all press events.
  - Any state -> ARMED on a CONTROL write with bit0 = 1. This clears the latches.
  - Any state -> IDLE on a CONTROL write with bit1 = 1. This also clears the latches.
  - Bit1 takes priority over bit0.
  - A CONTROL write on the same edge as a press event wins, and the press is discarded.
- Registers, word offset from `BASE_ADR`:
  - +0 STATUS (read-only):
    - bit0 = LOCKED
    - bits2:1 = `first_idx`
    - bit3 = ARMED
    - bits7:4 = `act[3:0]`
    - other bits 0
  - +1 CODE (read-only): {12'b0, `first_code`}.
  - +2 CONTROL (write-only): bit0 ARM, bit1 DISARM. Reads return 0.
  - +3 RAW (read-only): all 16 debounced bits, player 3 in bits 15:12.
- `rdata` is 0 unless `memread` and `hit` are both high. Reads have no side effects.
- A write to the RO offsets is ignored. `memread` and `memwrite` high together are treated as a write.
- Reset values:
  - `rdata` 0, `playerInputFlag` 0.
  - Synchronizers, debounced state, counters, `act` history, `first_idx` and `first_code` all 0.
  - FSM in IDLE.

## Timing
- A raw change that is stable from edge 0 reaches the synchronizer output at edge 2, and the debounced state at edge 2+`DEBOUNCE_CYCLES`.
- The LOCKED transition and the latches update at edge 3+`DEBOUNCE_CYCLES`. `playerInputFlag` rises on that same edge.
- A glitch shorter than `DEBOUNCE_CYCLES` synchronized cycles produces no debounced change.
- A CONTROL write takes effect on the rising edge where `memwrite` and the CONTROL address are both present.
- Read data is combinational from registers. This keeps it stable for `exmem`'s falling-edge sample.
- An `rst` assertion mid-lock forces IDLE immediately, without waiting for a clock edge. After release, the FSM stays in IDLE until an ARM write.

## Structure
- Package `player_io_pkg` holds:
  - register offsets `REG_STATUS`/`REG_CODE`/`REG_CONTROL`/`REG_RAW`
  - `CTRL_ARM`/`CTRL_DISARM` bit positions
  - STATUS bit positions
  - the `io_state_t` enum {IDLE, ARMED, LOCKED}
- Sub-module `debounce_bit`: synchronizer plus counter, parameterized by `DEBOUNCE_CYCLES` and `ACTIVE_LOW`. It is instantiated 16 times.
- The top level contains the edge detect, priority encoder, FSM and register decode.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `BASE_ADR`=43, `ACTIVE_LOW`=1.
- Reset then read 43: `rdata`=0 and `playerInputFlag`=0. Then drive `gpins[5]`=0 (player 1 button 1 pressed) while in IDLE: no lock, and RAW (46) = 16'h0020 after 6 cycles.
- Write 45 = 1, then hold `gpins[9]` low: flag rises exactly 7 cycles after the pin change. STATUS = 16'h0045 (LOCKED, idx 2, act bit 6), CODE = 16'h0002.
- In ARMED, drive `gpins[0]` and `gpins[12]` low on the same cycle: lock with idx 0 and CODE = 1. A later player 2 press leaves CODE and idx unchanged.
- 3-cycle low pulse on `gpins[4]` while ARMED: no lock and RAW stays 0. A 5-cycle pulse produces a lock.
- Write 45 = 3 while LOCKED: state goes to IDLE, STATUS = 0, flag falls on that edge. Write 45 = 1 in the same cycle as a press event: state goes to ARMED with no lock.
- Assert `rst` between clock edges while LOCKED: flag drops before the next edge. Reads to addresses 42 and 47 return 0 with `hit`=0.
